// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, state/phase types and the phase decode helper
// for the VGA raster timing controller.
package vga_timing_pkg;

  // Coordinate and counter width; every total must stay at or below 2047.
  localparam int CW = 11;

  // Default 640x480@60 timing (pixel clock ~25.175 MHz).
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_t;

  // Phase of an axis position; order from 0 is SYNC, BP, ACTIVE, FP.
  function automatic phase_t phase_of(input logic [CW-1:0] c,
                                      input logic [CW-1:0] s,
                                      input logic [CW-1:0] b,
                                      input logic [CW-1:0] a);
    if (c < s)
      return PH_SYNC;
    else if (c < s + b)
      return PH_BP;
    else if (c < s + b + a)
      return PH_ACT;
    else
      return PH_FP;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decode of the sync
// and active phases, the 1-based coordinate, and whether the position
// the counter moves to on the next step is active.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  parameter int ACT  = DEF_H_ACT,
  parameter int FP   = DEF_H_FP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          sync,
  output logic          act,
  output logic [CW-1:0] coord,
  output logic          next_act
);

  localparam logic [CW-1:0] L_SYNC  = CW'(SYNC);
  localparam logic [CW-1:0] L_BP    = CW'(BP);
  localparam logic [CW-1:0] L_ACT   = CW'(ACT);
  localparam logic [CW-1:0] L_START = CW'(SYNC + BP);
  localparam logic [CW-1:0] L_LAST  = CW'(SYNC + BP + ACT + FP - 1);

  logic [CW-1:0] cnt_step;

  // Position reached by one step, wrapping at the end of the axis.
  always_comb begin
    wrap     = (cnt == L_LAST);
    cnt_step = wrap ? '0 : cnt + CW'(1);
  end

  // Position register: clear wins over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (step)
      cnt <= cnt_step;
  end

  // Phase decode of the current and the upcoming position.
  always_comb begin
    sync     = (phase_of(cnt, L_SYNC, L_BP, L_ACT) == PH_SYNC);
    act      = (phase_of(cnt, L_SYNC, L_BP, L_ACT) == PH_ACT);
    coord    = act ? (cnt - L_START + CW'(1)) : '0;
    next_act = step ? (phase_of(cnt_step, L_SYNC, L_BP, L_ACT) == PH_ACT) : act;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: frame-aligned IDLE/RUN control, horizontal
// and vertical axis counters, and sync/blank/coordinate/strobe decode.
// All outputs decode the same state and counter registers, so sync,
// coordinates and the active qualifier change on the same clock edge.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP   = DEF_H_BP,
  parameter int   H_ACT  = DEF_H_ACT,
  parameter int   H_FP   = DEF_H_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP   = DEF_V_BP,
  parameter int   V_ACT  = DEF_V_ACT,
  parameter int   V_FP   = DEF_V_FP,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          VGA_CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  output logic          oHSYNC,
  output logic          oVSYNC,
  output logic          oSYNC_COLOR,
  output logic [CW-1:0] oCurrent_X,
  output logic [CW-1:0] oCurrent_Y,
  output logic          oPIX_REQ,
  output logic          oFRAME_START,
  output logic          oLINE_START,
  output state_t        state_dbg
);

  state_t        state, state_nxt;
  logic          run;
  logic          frame_end;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, h_sync, h_act, h_next_act;
  logic          v_wrap, v_sync, v_act, v_next_act;
  logic [CW-1:0] h_coord, v_coord;

  assign run       = (state == RUN);
  assign frame_end = run & h_wrap & v_wrap;
  assign state_dbg = state;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)
  ) u_h (
    .clk      (VGA_CLK),
    .rst_n    (RESET),
    .step     (run),
    .clear    (~run),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .sync     (h_sync),
    .act      (h_act),
    .coord    (h_coord),
    .next_act (h_next_act)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)
  ) u_v (
    .clk      (VGA_CLK),
    .rst_n    (RESET),
    .step     (run & h_wrap),
    .clear    (~run),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .sync     (v_sync),
    .act      (v_act),
    .coord    (v_coord),
    .next_act (v_next_act)
  );

  // FSM state register.
  always_ff @(posedge VGA_CLK or negedge RESET) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Start on ENABLE; stop only at the last cycle of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ENABLE) state_nxt = RUN;
      RUN:     if (frame_end && !ENABLE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, everything forced inactive outside RUN.
  always_comb begin
    oHSYNC       = ~HS_POL;
    oVSYNC       = ~VS_POL;
    oSYNC_COLOR  = 1'b0;
    oCurrent_X   = '0;
    oCurrent_Y   = '0;
    oPIX_REQ     = 1'b0;
    oFRAME_START = 1'b0;
    oLINE_START  = 1'b0;
    if (run) begin
      oHSYNC       = h_sync ? HS_POL : ~HS_POL;
      oVSYNC       = v_sync ? VS_POL : ~VS_POL;
      oSYNC_COLOR  = h_act & v_act;
      oCurrent_X   = h_act ? h_coord : '0;
      oCurrent_Y   = v_act ? v_coord : '0;
      oPIX_REQ     = h_next_act & v_next_act & ~(frame_end & ~ENABLE);
      oFRAME_START = (h_cnt == '0) && (v_cnt == '0);
      oLINE_START  = (h_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a 10x6 raster (H 2/2/4/2, V 1/1/3/1).
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int HT = 10;
  localparam int VT = 6;

  // Clock / reset
  logic        VGA_CLK = 1'b0;
  logic        RESET   = 1'b0;
  logic        ENABLE  = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  logic        oHSYNC, oVSYNC, oSYNC_COLOR, oPIX_REQ, oFRAME_START, oLINE_START;
  logic [10:0] oCurrent_X, oCurrent_Y;
  state_t      state_dbg;

  vga_timing_ctrl #(
    .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .VGA_CLK      (VGA_CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .oHSYNC       (oHSYNC),
    .oVSYNC       (oVSYNC),
    .oSYNC_COLOR  (oSYNC_COLOR),
    .oCurrent_X   (oCurrent_X),
    .oCurrent_Y   (oCurrent_Y),
    .oPIX_REQ     (oPIX_REQ),
    .oFRAME_START (oFRAME_START),
    .oLINE_START  (oLINE_START),
    .state_dbg    (state_dbg)
  );

  // Hand tables of the expected coordinate at each axis position.
  int x_tab [HT] = '{0, 0, 0, 0, 1, 2, 3, 4, 0, 0};
  int y_tab [VT] = '{0, 0, 1, 2, 3, 0};

  // Vector layout: {run, hsync, vsync, color, x[10:0], y[10:0], pix, frame, line}
  logic [28:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_vec    = 0;

  bit m_run = 1'b0;
  int m_h   = 0;
  int m_v   = 0;

  function automatic logic [28:0] exp_vec(input bit run, input int h, input int v);
    int   nh, nv;
    logic hs, vs, col, pix, fs, ls;
    logic [10:0] x, y;
    if (!run)
      return {1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0};
    nh  = (h == HT-1) ? 0 : h + 1;
    nv  = (h == HT-1) ? ((v == VT-1) ? 0 : v + 1) : v;
    hs  = (h >= 2);
    vs  = (v >= 1);
    x   = 11'(x_tab[h]);
    y   = 11'(y_tab[v]);
    col = (x_tab[h] != 0) && (y_tab[v] != 0);
    pix = !(h == HT-1 && v == VT-1) && (x_tab[nh] != 0) && (y_tab[nv] != 0);
    fs  = (h == 0) && (v == 0);
    ls  = (h == 0);
    return {1'b1, hs, vs, col, x, y, pix, fs, ls};
  endfunction

  // Driver: apply ENABLE for the next edge, push the expected result, wait.
  task automatic step(input bit en);
    ENABLE = en;
    if (!RESET) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_h = 0; m_v = 0; end
    end else if (m_h == HT-1 && m_v == VT-1 && !en) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else if (m_h == HT-1) begin
      m_h = 0;
      m_v = (m_v == VT-1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    exp_q.push_back(exp_vec(m_run, m_h, m_v));
    @(negedge VGA_CLK);
  endtask

  task automatic steps(input bit en, input int n);
    for (int i = 0; i < n; i++) step(en);
  endtask

  // Scoreboard monitor plus per-frame statistics.
  logic [28:0] got, exp_v;
  int  f_cyc = 0, f_pix = 0, f_vlow = 0;
  bit  f_prev = 1'b0, f_broken = 1'b0;

  always @(posedge VGA_CLK or negedge RESET) begin
    #1;
    got = {state_dbg == RUN, oHSYNC, oVSYNC, oSYNC_COLOR, oCurrent_X, oCurrent_Y,
           oPIX_REQ, oFRAME_START, oLINE_START};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL outputs vec=%0d t=%0t got=%h exp=%h", n_vec, $time, got, exp_v);
      end
      n_vec++;
    end
    if (VGA_CLK) begin
      if (oFRAME_START) begin
        if (f_prev && !f_broken) begin
          n_checks++;
          if (f_cyc != 60) begin
            n_errors++;
            $display("FAIL frame_gap got=%0d exp=60", f_cyc);
          end
          n_checks++;
          if (f_pix != 12) begin
            n_errors++;
            $display("FAIL active_pixels got=%0d exp=12", f_pix);
          end
          n_checks++;
          if (f_vlow != 10) begin
            n_errors++;
            $display("FAIL vsync_low got=%0d exp=10", f_vlow);
          end
        end
        f_cyc = 0; f_pix = 0; f_vlow = 0; f_broken = 1'b0; f_prev = 1'b1;
      end
      if (state_dbg != RUN) f_broken = 1'b1;
      f_cyc++;
      if (oSYNC_COLOR) f_pix++;
      if (!oVSYNC) f_vlow++;
    end
  end

  // Stimulus
  initial begin
    RESET  = 1'b0;
    ENABLE = 1'b1;
    @(negedge VGA_CLK);
    // Held in reset with ENABLE high: reset values only.
    steps(1'b1, 3);
    // Release: first RUN cycle is the frame start, then one full frame.
    RESET = 1'b1;
    steps(1'b1, 60);
    // Seamless next frame, then drop ENABLE mid-frame and run out to IDLE.
    steps(1'b1, 25);
    steps(1'b0, 35);
    steps(1'b0, 4);
    // Restart and run to h=5 on the first active line.
    steps(1'b1, 26);
    // Asynchronous reset mid-line: outputs clear without a clock edge.
    m_run = 1'b0; m_h = 0; m_v = 0;
    exp_q.push_back(exp_vec(1'b0, 0, 0));
    RESET = 1'b0;
    steps(1'b1, 2);
    RESET = 1'b1;
    steps(1'b1, 12);
    // Let the monitor drain any outstanding entry.
    @(posedge VGA_CLK);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
